// File: rtl/ifetch_bus_ctrl.sv
// ============================================================================
//  Module   : ifetch_bus_ctrl
//  Purpose  : Instruction-side bus master sitting behind the fetch-stage PC.
//             Accepts a fetch request (PC + valid), runs a split address/data
//             handshake on the instruction bus, and presents the returned
//             word together with its PC to decode. Requests a pipeline stall
//             while a fetch is outstanding and discards in-flight data when
//             a flush arrives.
//  Ports    : clk, reset (synchronous, active-high)
//             req_valid / req_pc        - fetch request from the PC stage
//             flush                     - squash the current fetch and output
//             stall_d                   - decode back-pressure
//             ibus_req_valid / ibus_req_addr / ibus_addr_ok /
//             ibus_data_ok / ibus_data  - instruction bus
//             instr_valid / instr / instr_pc - result to decode
//             fetch_busy                - stall request to the pipeline
//             adel                      - address-error flag (optional)
//  Options  : IFETCH_ALIGN_CHECK_EN - when defined, PCs with req_pc[1:0]!=0
//             never reach the bus; a NOP is returned with adel set instead.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_bus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              flush,
  input  logic              stall_d,
  output logic              ibus_req_valid,
  output logic [ADDR_W-1:0] ibus_req_addr,
  input  logic              ibus_addr_ok,
  input  logic              ibus_data_ok,
  input  logic [DATA_W-1:0] ibus_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_busy
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              adel
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;

  logic w_accept;
  logic w_misalign;
  logic w_complete;

  // A new fetch may only start from IDLE, never during a flush, and never
  // while decode is still refusing the instruction currently on the output.
  assign w_accept = (state_q == IDLE) && req_valid && !flush &&
                    !(instr_valid_q && stall_d);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic adel_q, adel_d;
  assign w_misalign = (req_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Data phase finishes either together with the address phase or later.
  assign w_complete = ((state_q == REQ) && ibus_addr_ok && ibus_data_ok) ||
                      ((state_q == WAIT) && ibus_data_ok);

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    addr_d        = addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    adel_d        = adel_q;
`endif

    // Consume by decode, then flush; a completion below overrides both.
    if ((instr_valid_q && !stall_d) || flush) begin
      instr_valid_d = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      adel_d        = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (w_misalign) begin
            // Misaligned PC: answer locally with a NOP, bus stays quiet.
            instr_valid_d = 1'b1;
            instr_d       = '0;
            instr_pc_d    = req_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
            adel_d        = 1'b1;
`endif
          end else begin
            addr_d  = req_pc;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (ibus_addr_ok) begin
          state_d = ibus_data_ok ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (ibus_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_complete) begin
      // A flush landing on the data cycle drops that data too.
      if (drop_q || flush) begin
        drop_d = 1'b0;
      end else begin
        instr_valid_d = 1'b1;
        instr_d       = ibus_data;
        instr_pc_d    = addr_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        adel_d        = 1'b0;
`endif
      end
    end else if (flush && (state_q != IDLE)) begin
      // The bus transaction cannot be withdrawn; remember to discard it.
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      addr_q        <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      adel_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      addr_q        <= addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      adel_q        <= adel_d;
`endif
    end
  end

  assign ibus_req_valid = (state_q == REQ);
  assign ibus_req_addr  = addr_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign fetch_busy     = (state_q == REQ) || (state_q == WAIT) || w_accept;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign adel           = adel_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_bus_ctrl.sv
`default_nettype none

module tb_ifetch_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        flush;
  logic        stall_d;
  logic        ibus_req_valid;
  logic [31:0] ibus_req_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [31:0] ibus_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_busy;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        adel;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .flush          (flush),
    .stall_d        (stall_d),
    .ibus_req_valid (ibus_req_valid),
    .ibus_req_addr  (ibus_req_addr),
    .ibus_addr_ok   (ibus_addr_ok),
    .ibus_data_ok   (ibus_data_ok),
    .ibus_data      (ibus_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_busy     (fetch_busy)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .adel           (adel)
`endif
  );

  // Inputs change on the falling edge; outputs are compared 1 ns later.
  task automatic quiet_inputs;
    req_valid = 1'b0; req_pc = '0; flush = 1'b0; stall_d = 1'b0;
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; ibus_data = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; quiet_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    total++; if (ibus_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", ibus_req_valid); end
    total++; if (ibus_req_addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr got=%h exp=0", ibus_req_addr); end
    total++; if ({instr_valid, instr, instr_pc} !== 65'h0) begin bad++; $display("FAIL reset_outputs got=%b/%h/%h exp=0/0/0", instr_valid, instr, instr_pc); end
    total++; if (fetch_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", fetch_busy); end
`ifdef IFETCH_ALIGN_CHECK_EN
    total++; if (adel !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", adel); end
`endif
  endtask

  task automatic test_zero_wait;
    @(negedge clk); req_valid = 1'b1; req_pc = 32'hBFC00000; #1;
    total++; if (fetch_busy !== 1'b1 || ibus_req_valid !== 1'b0) begin bad++; $display("FAIL zw_accept busy/rv got=%b/%b exp=1/0", fetch_busy, ibus_req_valid); end
    @(negedge clk); req_valid = 1'b0; ibus_addr_ok = 1'b1; ibus_data_ok = 1'b1; ibus_data = 32'h24080001; #1;
    total++; if (ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'hBFC00000) begin bad++; $display("FAIL zw_req got=%b/%h exp=1/bfc00000", ibus_req_valid, ibus_req_addr); end
    @(negedge clk); ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h24080001 || instr_pc !== 32'hBFC00000) begin bad++; $display("FAIL zw_deliver got=%b/%h/%h exp=1/24080001/bfc00000", instr_valid, instr, instr_pc); end
    total++; if (ibus_req_valid !== 1'b0 || fetch_busy !== 1'b0) begin bad++; $display("FAIL zw_idle rv/busy got=%b/%b exp=0/0", ibus_req_valid, fetch_busy); end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL zw_consume got=%b exp=0", instr_valid); end
  endtask

  task automatic test_wait_states;
    @(negedge clk); req_valid = 1'b1; req_pc = 32'hBFC00100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_valid = 1'b0; ibus_addr_ok = (i == 2); #1;
      total++; if (ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'hBFC00100 || fetch_busy !== 1'b1) begin bad++; $display("FAIL ws_req_hold[%0d] got=%b/%h/%b exp=1/bfc00100/1", i, ibus_req_valid, ibus_req_addr, fetch_busy); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ibus_addr_ok = 1'b0; ibus_data_ok = (i == 2); ibus_data = 32'h8C090004; #1;
      total++; if (ibus_req_valid !== 1'b0 || fetch_busy !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL ws_wait[%0d] got=%b/%b/%b exp=0/1/0", i, ibus_req_valid, fetch_busy, instr_valid); end
    end
    @(negedge clk); ibus_data_ok = 1'b0; #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h8C090004 || instr_pc !== 32'hBFC00100 || fetch_busy !== 1'b0) begin bad++; $display("FAIL ws_deliver got=%b/%h/%h/%b exp=1/8c090004/bfc00100/0", instr_valid, instr, instr_pc, fetch_busy); end
    @(negedge clk); #1;
  endtask

  task automatic test_flush_wait;
    @(negedge clk); req_valid = 1'b1; req_pc = 32'hBFC00200;
    @(negedge clk); req_valid = 1'b0; ibus_addr_ok = 1'b1;
    @(negedge clk); ibus_addr_ok = 1'b0; flush = 1'b1; req_valid = 1'b1; req_pc = 32'hBFC00380; #1;
    total++; if (fetch_busy !== 1'b1 || ibus_req_valid !== 1'b0) begin bad++; $display("FAIL fl_wait busy/rv got=%b/%b exp=1/0", fetch_busy, ibus_req_valid); end
    @(negedge clk); flush = 1'b0; ibus_data_ok = 1'b1; ibus_data = 32'hDEADBEEF; #1;
    total++; if (ibus_req_valid !== 1'b0) begin bad++; $display("FAIL fl_no_early_req got=%b exp=0", ibus_req_valid); end
    @(negedge clk); ibus_data_ok = 1'b0; #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fl_dropped got=%b exp=0", instr_valid); end
    total++; if (fetch_busy !== 1'b1) begin bad++; $display("FAIL fl_new_accept got=%b exp=1", fetch_busy); end
    @(negedge clk); req_valid = 1'b0; ibus_addr_ok = 1'b1; ibus_data_ok = 1'b1; ibus_data = 32'h3C1DA000; #1;
    total++; if (ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'hBFC00380) begin bad++; $display("FAIL fl_new_req got=%b/%h exp=1/bfc00380", ibus_req_valid, ibus_req_addr); end
    @(negedge clk); ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; stall_d = 1'b1; #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h3C1DA000 || instr_pc !== 32'hBFC00380) begin bad++; $display("FAIL fl_new_deliver got=%b/%h/%h exp=1/3c1da000/bfc00380", instr_valid, instr, instr_pc); end
  endtask

  // Entered with 0x3C1DA000 @ 0xBFC00380 on the output and stall_d high.
  task automatic test_stall_hold;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); stall_d = 1'b1; req_valid = 1'b1; req_pc = 32'hBFC00384; #1;
      total++; if (instr_valid !== 1'b1 || instr !== 32'h3C1DA000 || instr_pc !== 32'hBFC00380) begin bad++; $display("FAIL st_hold[%0d] got=%b/%h/%h exp=1/3c1da000/bfc00380", i, instr_valid, instr, instr_pc); end
      total++; if (ibus_req_valid !== 1'b0 || fetch_busy !== 1'b0) begin bad++; $display("FAIL st_no_req[%0d] got=%b/%b exp=0/0", i, ibus_req_valid, fetch_busy); end
    end
    @(negedge clk); stall_d = 1'b0; #1;
    total++; if (fetch_busy !== 1'b1) begin bad++; $display("FAIL st_release_accept got=%b exp=1", fetch_busy); end
    @(negedge clk); req_valid = 1'b0; ibus_addr_ok = 1'b1; ibus_data_ok = 1'b1; ibus_data = 32'h27BDFFF8; #1;
    total++; if (ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'hBFC00384 || instr_valid !== 1'b0) begin bad++; $display("FAIL st_req_consumed got=%b/%h/%b exp=1/bfc00384/0", ibus_req_valid, ibus_req_addr, instr_valid); end
    @(negedge clk); ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h27BDFFF8 || instr_pc !== 32'hBFC00384) begin bad++; $display("FAIL st_deliver got=%b/%h/%h exp=1/27bdfff8/bfc00384", instr_valid, instr, instr_pc); end
    @(negedge clk); #1;
  endtask

  // Flush on the data cycle drops that word; a flush also beats stall_d.
  task automatic test_flush_same_cycle;
    @(negedge clk); req_valid = 1'b1; req_pc = 32'hBFC00500;
    @(negedge clk); req_valid = 1'b0; flush = 1'b1; ibus_addr_ok = 1'b1; ibus_data_ok = 1'b1; ibus_data = 32'h11111111;
    @(negedge clk); flush = 1'b0; ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; #1;
    total++; if (instr_valid !== 1'b0 || fetch_busy !== 1'b0) begin bad++; $display("FAIL fs_dropped got=%b/%b exp=0/0", instr_valid, fetch_busy); end
    req_valid = 1'b1; req_pc = 32'hBFC00504;
    @(negedge clk); req_valid = 1'b0; ibus_addr_ok = 1'b1; ibus_data_ok = 1'b1; ibus_data = 32'h22222222;
    @(negedge clk); ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; stall_d = 1'b1; #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h22222222 || instr_pc !== 32'hBFC00504) begin bad++; $display("FAIL fs_next_deliver got=%b/%h/%h exp=1/22222222/bfc00504", instr_valid, instr, instr_pc); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; stall_d = 1'b0; #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fs_flush_over_stall got=%b exp=0", instr_valid); end
  endtask

  task automatic test_reset_mid_req;
    @(negedge clk); req_valid = 1'b1; req_pc = 32'hBFC00400;
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (ibus_req_valid !== 1'b1) begin bad++; $display("FAIL rm_in_req got=%b exp=1", ibus_req_valid); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    total++; if ({ibus_req_valid, ibus_req_addr, instr_valid, instr, instr_pc, fetch_busy} !== 99'h0) begin bad++; $display("FAIL rm_cleared got=%b/%h/%b/%h/%h/%b exp=all 0", ibus_req_valid, ibus_req_addr, instr_valid, instr, instr_pc, fetch_busy); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++; if (instr_valid !== 1'b0 || ibus_req_valid !== 1'b0) begin bad++; $display("FAIL rm_quiet[%0d] got=%b/%b exp=0/0", i, instr_valid, ibus_req_valid); end
    end
  endtask

`ifdef IFETCH_ALIGN_CHECK_EN
  task automatic test_align;
    @(negedge clk); req_valid = 1'b1; req_pc = 32'hBFC00002; #1;
    total++; if (ibus_req_valid !== 1'b0) begin bad++; $display("FAIL al_no_req got=%b exp=0", ibus_req_valid); end
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (ibus_req_valid !== 1'b0 || instr_valid !== 1'b1 || adel !== 1'b1 || instr !== 32'h0 || instr_pc !== 32'hBFC00002) begin bad++; $display("FAIL al_nop got=%b/%b/%b/%h/%h exp=0/1/1/0/bfc00002", ibus_req_valid, instr_valid, adel, instr, instr_pc); end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b0 || adel !== 1'b0) begin bad++; $display("FAIL al_consume got=%b/%b exp=0/0", instr_valid, adel); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_flush_wait();
    test_stall_hold();
    test_flush_same_cycle();
    test_reset_mid_req();
`ifdef IFETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
